// File: rtl/load_store_unit.sv
// load_store_unit: byte/halfword/word load-store engine in front of a single-port data memory.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      request handshake (ready only while idle)
//   req_we, req_size,        store/load select, 00 byte / 01 half / 10 word,
//   req_unsigned             zero- vs sign-extension for loads
//   req_addr, req_wdata      byte address, store data (low-order lanes)
//   rsp_valid, rsp_rdata,    one-cycle completion pulse, load result,
//   rsp_fault                rejected request
//   mem_address, mem_w_data, word address and merged store word,
//   mem_r_data               combinational read data,
//   mem_ctrl_r, mem_ctrl_w   read / write enables
package common_pkg;
  localparam int RISC_V_DATA_WIDTH = 32;
  localparam int DATA_MEMORY_ADDRESS_WIDTH = 8;
  localparam int DATA_MEMORY_ROM_DEPTH = 64;
endpackage

module load_store_unit
  import common_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic                                 req_we,
  input  logic [1:0]                           req_size,
  input  logic                                 req_unsigned,
  input  logic [31:0]                          req_addr,
  input  logic [RISC_V_DATA_WIDTH-1:0]         req_wdata,
  output logic                                 rsp_valid,
  output logic [RISC_V_DATA_WIDTH-1:0]         rsp_rdata,
  output logic                                 rsp_fault,
  output logic [DATA_MEMORY_ADDRESS_WIDTH-1:0] mem_address,
  output logic [RISC_V_DATA_WIDTH-1:0]         mem_w_data,
  input  logic [RISC_V_DATA_WIDTH-1:0]         mem_r_data,
  output logic                                 mem_ctrl_r,
  output logic                                 mem_ctrl_w
);
  localparam int AW = DATA_MEMORY_ADDRESS_WIDTH;
  localparam logic [AW-1:0] ROM_LIM = AW'(DATA_MEMORY_ROM_DEPTH);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  state_t state_q, state_d;
  logic accept, fault;
  logic we_q, we_d, uns_q, uns_d, fault_q, fault_d;
  logic [1:0] size_q, size_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, data_q, data_d;
  logic [7:0] byte_v;
  logic [15:0] half_v;
  logic [31:0] load_v, mask, rep, merged;
  assign accept = state_q == IDLE && req_valid;
  // Stores into the ROM window are rejected up front so the write enable never fires there.
  assign fault = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) ||
                 (req_size == 2'b10 && |req_addr[1:0]) || |req_addr[31:AW+2] ||
                 (req_we && req_addr[AW+1:2] < ROM_LIM);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      fault_q <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      fault_q <= fault_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
    end
  end
  always_comb begin
    state_d = state_q == IDLE  ? (req_valid ? (fault ? RESP : READ) : IDLE) :
              state_q == READ  ? (we_q ? WRITE : RESP) :
              state_q == WRITE ? RESP : IDLE;
  end
  always_comb begin
    we_d    = accept ? req_we : we_q;
    uns_d   = accept ? req_unsigned : uns_q;
    fault_d = accept ? fault : fault_q;
    size_d  = accept ? req_size : size_q;
    addr_d  = accept ? req_addr[AW+1:0] : addr_q;
    wdata_d = accept ? req_wdata : wdata_q;
    byte_v  = mem_r_data[{addr_q[1:0], 3'b000} +: 8];
    half_v  = mem_r_data[{addr_q[1], 4'b0000} +: 16];
    load_v  = size_q == 2'b00 ? {{24{~uns_q & byte_v[7]}}, byte_v} :
              size_q == 2'b01 ? {{16{~uns_q & half_v[15]}}, half_v} : mem_r_data;
    mask    = size_q == 2'b00 ? 32'h0000_00FF << {addr_q[1:0], 3'b000} :
              size_q == 2'b01 ? 32'h0000_FFFF << {addr_q[1], 4'b0000} : 32'hFFFF_FFFF;
    rep     = size_q == 2'b00 ? {4{wdata_q[7:0]}} :
              size_q == 2'b01 ? {2{wdata_q[15:0]}} : wdata_q;
    merged  = (mem_r_data & ~mask) | (rep & mask);
    // One register serves both paths: merged word for stores, extracted lane for loads.
    data_d  = state_q == READ ? (we_q ? merged : load_v) : data_q;
  end
  always_comb begin
    req_ready   = state_q == IDLE;
    mem_ctrl_r  = state_q == READ;
    mem_ctrl_w  = state_q == WRITE;
    mem_address = (state_q == READ || state_q == WRITE) ? addr_q[AW+1:2] : '0;
    mem_w_data  = state_q == WRITE ? data_q : '0;
    rsp_valid   = state_q == RESP;
    rsp_fault   = state_q == RESP && fault_q;
    rsp_rdata   = (state_q == RESP && !fault_q && !we_q) ? data_q : '0;
  end
endmodule
